// File: rtl/display_scheduler.sv
// Draw scheduler for the slide-puzzle display engine: keeps a shadow board of
// tile IDs plus a dirty mask and issues one plot or wipe at a time.
module display_scheduler #(
  parameter logic [2:0] TILE_SPRITE = 3'd1,
  parameter int TO_W = 15,
  parameter logic [TO_W-1:0] TIMEOUT = 15'd32767
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       upd_valid,
  input  logic [3:0] upd_addr,
  input  logic [3:0] upd_id,
  input  logic       screen_req,
  input  logic [2:0] screen_sel,
  input  logic       screen_redraw,
  input  logic       done,
  output logic [3:0] address,
  output logic [3:0] ID,
  output logic       plot,
  output logic       load_sprite,
  output logic [2:0] sprite_sel,
  output logic       busy,
  output logic       screen_ack,
  output logic       timeout_err
);

  // Handshake: plot/load_sprite are single-cycle requests; address, ID and
  // sprite_sel stay stable from the request until done (or watchdog expiry).
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_PLOT_REQ, S_PLOT_WAIT, S_WIPE_REQ, S_WIPE_WAIT
  } state_t;

  // The counter starts one cycle after the request and the error flag adds a
  // register stage, so matching two early flags expiry TIMEOUT cycles after it.
  localparam logic [TO_W-1:0] L_TO_HIT = TIMEOUT - TO_W'(2);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_ptr;
  logic [15:0]     r_dirty;
  logic [15:0]     w_dirty_nxt;
  logic [3:0]      r_table [16];
  logic            r_pend;
  logic [2:0]      r_sel_lat;
  logic            r_redraw_lat;
  logic            r_wipe_redraw;
  logic [TO_W-1:0] r_wdog;
  logic [3:0]      r_address;
  logic [3:0]      r_id;
  logic [2:0]      r_sprite_sel;
  logic            r_timeout_err;
  logic            w_to_hit;

  assign w_to_hit = (r_wdog == L_TO_HIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend)                w_next = S_WIPE_REQ;
        else if (r_dirty != 16'h0) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_pend)                w_next = S_WIPE_REQ;
        else if (r_dirty == 16'h0) w_next = S_IDLE;
        else if (r_dirty[r_ptr])   w_next = S_PLOT_REQ;
      end
      S_PLOT_REQ:  w_next = S_PLOT_WAIT;
      S_PLOT_WAIT: if (done || w_to_hit) w_next = S_IDLE;
      S_WIPE_REQ:  w_next = S_WIPE_WAIT;
      S_WIPE_WAIT: if (done || w_to_hit) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    plot        = (r_state == S_PLOT_REQ);
    load_sprite = (r_state == S_WIPE_REQ);
    screen_ack  = (r_state == S_WIPE_WAIT) && done;
    busy        = (r_state != S_IDLE) || r_pend || (r_dirty != 16'h0);
    sprite_sel  = (r_state == S_WIPE_REQ) ? r_sel_lat : r_sprite_sel;
    address     = r_address;
    ID          = r_id;
    timeout_err = r_timeout_err;
  end

  // A cell stays dirty if its table entry changed after the ID was latched.
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (r_state == S_PLOT_REQ && r_table[r_ptr] == r_id) w_dirty_nxt[r_ptr] = 1'b0;
    if (r_state == S_WIPE_WAIT && done && r_wipe_redraw) w_dirty_nxt = 16'hFFFF;
    if (upd_valid) w_dirty_nxt[upd_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr         <= 4'd0;
      r_dirty       <= 16'h0000;
      for (int i = 0; i < 16; i++) r_table[i] <= 4'(i);
      r_pend        <= 1'b0;
      r_sel_lat     <= 3'd0;
      r_redraw_lat  <= 1'b0;
      r_wipe_redraw <= 1'b0;
      r_wdog        <= '0;
      r_address     <= 4'd0;
      r_id          <= 4'd0;
      r_sprite_sel  <= 3'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dirty <= w_dirty_nxt;
      if (upd_valid) r_table[upd_addr] <= upd_id;
      if (screen_req) begin
        r_pend       <= 1'b1;
        r_sel_lat    <= screen_sel;
        r_redraw_lat <= screen_redraw;
      end else if (r_state == S_WIPE_REQ) begin
        r_pend <= 1'b0;
      end
      case (r_state)
        S_SCAN: begin
          if (!r_pend && r_dirty != 16'h0) begin
            if (r_dirty[r_ptr]) begin
              r_address    <= r_ptr;
              r_id         <= r_table[r_ptr];
              r_sprite_sel <= TILE_SPRITE;
            end else begin
              r_ptr <= r_ptr + 4'd1;
            end
          end
        end
        S_PLOT_REQ: r_wdog <= '0;
        S_PLOT_WAIT: begin
          if (done)          r_ptr <= r_ptr + 4'd1;
          else if (w_to_hit) r_timeout_err <= 1'b1;
          else               r_wdog <= r_wdog + TO_W'(1);
        end
        S_WIPE_REQ: begin
          r_wdog        <= '0;
          r_sprite_sel  <= r_sel_lat;
          r_wipe_redraw <= r_redraw_lat;
        end
        S_WIPE_WAIT: begin
          if (!done) begin
            if (w_to_hit) r_timeout_err <= 1'b1;
            else          r_wdog <= r_wdog + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus random traffic, checked
// every cycle against a transaction-level board/dirty/screen model.
module tb_display_scheduler;
  localparam logic [2:0] TILE_SPRITE = 3'd1;
  localparam int TIMEOUT = 32767;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic upd_valid = 1'b0;
  logic [3:0] upd_addr = 4'd0;
  logic [3:0] upd_id = 4'd0;
  logic screen_req = 1'b0;
  logic [2:0] screen_sel = 3'd0;
  logic screen_redraw = 1'b0;
  logic done = 1'b0;
  logic [3:0] address, ID;
  logic plot, load_sprite, busy, screen_ack, timeout_err;
  logic [2:0] sprite_sel;

  display_scheduler dut (
    .clk(clk), .resetn(resetn), .upd_valid(upd_valid), .upd_addr(upd_addr),
    .upd_id(upd_id), .screen_req(screen_req), .screen_sel(screen_sel),
    .screen_redraw(screen_redraw), .done(done), .address(address), .ID(ID),
    .plot(plot), .load_sprite(load_sprite), .sprite_sel(sprite_sel),
    .busy(busy), .screen_ack(screen_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // model of what the display must show
  logic [3:0]  m_table [16];
  logic [3:0]  m_table_prev [16];
  logic [15:0] m_dirty;
  logic        m_pend, m_pend_prev, m_redraw, m_prev_pulse;
  logic [2:0]  m_sel;
  logic        m_out, m_out_wipe, m_wipe_redraw, m_err;
  int          m_start, m_last_done;
  logic [3:0]  h_addr, h_id;
  logic [2:0]  h_sel;
  logic [4:0]  m_screen [16];
  logic [15:0] m_touched;
  int          n_ack = 0;
  logic [7:0]  exp_q[$];

  int eng_left = 0;
  bit eng_mute = 0;
  bit spurious_en = 0;
  int eng_lat_min = 10;
  int eng_lat_max = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_table[i] = 4'(i);
      m_table_prev[i] = 4'(i);
      m_screen[i] = 5'h10;
    end
    m_dirty = 16'h0; m_pend = 0; m_pend_prev = 0; m_redraw = 0; m_sel = 3'd0;
    m_prev_pulse = 0; m_out = 0; m_out_wipe = 0; m_wipe_redraw = 0; m_err = 0;
    m_start = 0; m_last_done = -100; m_touched = 16'h0;
  endfunction

  // compare process: outputs vs model every cycle, then advance the model
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        m_reset();
        continue;
      end
      check("timeout_err", timeout_err, m_err);
      check("busy", busy, (m_dirty != 16'h0) || m_pend || m_out);
      check("screen_ack", screen_ack, m_out && m_out_wipe && done);
      if (plot || load_sprite) begin
        check("pulse_excl", plot && load_sprite, 0);
        check("pulse_gap", m_prev_pulse, 0);
        check("pulse_while_outstanding", m_out, 0);
        check("pulse_after_done", (cyc - m_last_done) >= 2, 1);
      end
      if (plot) begin
        check("plot_dirty", m_dirty[address], 1);
        check("plot_id", ID, m_table_prev[address]);
        check("plot_sel", sprite_sel, TILE_SPRITE);
        check("plot_wipe_prio", m_pend_prev, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("plot_order", {address, ID}, e);
        end
      end
      if (load_sprite) begin
        check("load_pend", m_pend, 1);
        check("load_sel", sprite_sel, m_sel);
      end
      if (m_out) begin
        check("hold_sel", sprite_sel, h_sel);
        if (!m_out_wipe) begin
          check("hold_addr", address, h_addr);
          check("hold_id", ID, h_id);
        end
      end
      m_pend_prev = m_pend;
      m_table_prev = m_table;
      m_prev_pulse = plot || load_sprite;
      if (plot) begin
        m_out = 1; m_out_wipe = 0; m_start = cyc;
        h_addr = address; h_id = ID; h_sel = sprite_sel;
        if (m_table[address] == ID) m_dirty[address] = 1'b0;
        if (!eng_mute) eng_left = $urandom_range(eng_lat_max, eng_lat_min);
      end else if (load_sprite) begin
        m_out = 1; m_out_wipe = 1; m_start = cyc; h_sel = sprite_sel;
        m_wipe_redraw = m_redraw; m_pend = 0;
        if (!eng_mute) eng_left = $urandom_range(eng_lat_max, eng_lat_min);
      end else if (m_out) begin
        if (done) begin
          m_out = 0; m_last_done = cyc;
          if (!m_out_wipe) m_screen[h_addr] = {1'b0, h_id};
          else begin
            n_ack++;
            for (int i = 0; i < 16; i++) m_screen[i] = 5'h10;
            if (m_wipe_redraw) begin m_dirty = 16'hFFFF; m_touched = 16'hFFFF; end
            else m_touched = m_dirty;
          end
        end else if (cyc - m_start == TIMEOUT - 1) begin
          m_out = 0; m_err = 1;
        end
      end
      if (upd_valid) begin
        m_table[upd_addr] = upd_id;
        m_dirty[upd_addr] = 1'b1;
        m_touched[upd_addr] = 1'b1;
      end
      if (screen_req) begin
        m_pend = 1; m_sel = screen_sel; m_redraw = screen_redraw;
      end
    end
  end

  // engine: done a programmable number of cycles after each request
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin eng_left = 0; done = 0; end
      else if (eng_left == 1) begin done = 1; eng_left = 0; end
      else begin
        done = spurious_en && (eng_left == 0) && ($urandom_range(0, 29) == 0);
        if (eng_left > 1) eng_left--;
      end
    end
  end

  task automatic drive_cycle(input logic uv, input logic [3:0] a, input logic [3:0] id,
                             input logic sr, input logic [2:0] sel, input logic rd);
    @(posedge clk); #1;
    upd_valid = uv; upd_addr = a; upd_id = id;
    screen_req = sr; screen_sel = sel; screen_redraw = rd;
  endtask

  task automatic upd(input logic [3:0] a, input logic [3:0] id);
    drive_cycle(1'b1, a, id, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic scr(input logic [2:0] sel, input logic rd);
    drive_cycle(1'b0, 4'd0, 4'd0, 1'b1, sel, rd);
  endtask

  task automatic step();
    drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0;
    upd_valid = 0; screen_req = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    exp_q.delete();
  endtask

  task automatic wait_plot(input logic [3:0] a, input int max);
    int n;
    n = 0;
    do begin step(); n++; end while (!(plot && address == a) && n < max);
    check("wait_plot", plot && address == a, 1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin step(); n++; end while (busy && n < max);
    check("wait_idle", busy, 0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, acks, touched;
    do_reset();
    step();
    check("rst_address", address, 0);
    check("rst_id", ID, 0);
    check("rst_plot", plot, 0);
    check("rst_load", load_sprite, 0);
    check("rst_sel", sprite_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", screen_ack, 0);
    check("rst_err", timeout_err, 0);

    // 1: single update, 520-cycle engine
    eng_lat_min = 520; eng_lat_max = 520;
    exp_q.push_back({4'd5, 4'd9});
    upd(4'd5, 4'd9);
    wait_plot(4'd5, 100);
    check("t1_id", ID, 9);
    check("t1_sel", sprite_sel, 1);
    n = 0;
    do begin step(); n++; end while (!done && n < 600);
    check("t1_done_latency", n, 520);
    n = 0;
    do begin step(); n++; end while (busy && n < 100);
    check("t1_busy_fall", n <= 20, 1);
    check("t1_queue", exp_q.size(), 0);

    // 2: three updates while a wipe is in flight, drawn in round-robin order
    do_reset();
    eng_lat_min = 30; eng_lat_max = 30;
    acks = n_ack;
    scr(3'd0, 1'b0);
    n = 0;
    do begin step(); n++; end while (!load_sprite && n < 50);
    check("t2_load", load_sprite, 1);
    exp_q.push_back({4'd0, 4'hC});
    exp_q.push_back({4'd3, 4'hA});
    exp_q.push_back({4'd12, 4'h6});
    upd(4'd3, 4'hA);
    upd(4'd12, 4'h6);
    upd(4'd0, 4'hC);
    wait_idle(1000);
    check("t2_queue", exp_q.size(), 0);
    check("t2_acks", n_ack - acks, 1);

    // 3: wipe with redraw requested during cell 7's draw
    do_reset();
    eng_lat_min = 40; eng_lat_max = 40;
    acks = n_ack;
    exp_q.push_back({4'd7, 4'd3});
    for (int i = 8; i < 16; i++) exp_q.push_back({4'(i), 4'(i)});
    for (int i = 0; i < 7; i++) exp_q.push_back({4'(i), 4'(i)});
    exp_q.push_back({4'd7, 4'd3});
    upd(4'd7, 4'd3);
    wait_plot(4'd7, 100);
    scr(3'd0, 1'b1);
    wait_idle(3000);
    check("t3_queue", exp_q.size(), 0);
    check("t3_acks", n_ack - acks, 1);

    // 4: update lands in the plot cycle of the same cell
    do_reset();
    eng_lat_min = 20; eng_lat_max = 20;
    exp_q.push_back({4'd4, 4'd7});
    exp_q.push_back({4'd4, 4'd2});
    upd(4'd4, 4'd7);
    wait_plot(4'd4, 100);
    upd_valid = 1; upd_addr = 4'd4; upd_id = 4'd2;
    wait_idle(500);
    check("t4_queue", exp_q.size(), 0);

    // 5: engine never answers the first plot
    do_reset();
    eng_lat_min = 15; eng_lat_max = 15;
    eng_mute = 1;
    exp_q.push_back({4'd1, 4'd3});
    exp_q.push_back({4'd2, 4'd5});
    upd(4'd1, 4'd3);
    upd(4'd2, 4'd5);
    wait_plot(4'd1, 100);
    n = 0;
    do begin step(); n++; end while (!timeout_err && n < 33000);
    eng_mute = 0;
    check("t5_timeout_cycles", n, TIMEOUT);
    wait_idle(500);
    check("t5_queue", exp_q.size(), 0);
    check("t5_sticky", timeout_err, 1);

    // 6: reset in the middle of a draw
    eng_lat_min = 200; eng_lat_max = 200;
    exp_q.push_back({4'd9, 4'd1});
    upd(4'd9, 4'd1);
    upd(4'd10, 4'd2);
    wait_plot(4'd9, 100);
    repeat (3) step();
    resetn = 0;
    #1;
    check("t6_address", address, 0);
    check("t6_id", ID, 0);
    check("t6_plot", plot, 0);
    check("t6_load", load_sprite, 0);
    check("t6_sel", sprite_sel, 0);
    check("t6_busy", busy, 0);
    check("t6_ack", screen_ack, 0);
    check("t6_err", timeout_err, 0);
    repeat (2) step();
    @(posedge clk); #1 resetn = 1;
    exp_q.delete();
    repeat (5) begin step(); check("t6_idle_after_reset", busy, 0); end
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 4'(i)});
    eng_lat_min = 12; eng_lat_max = 12;
    scr(3'd5, 1'b1);
    wait_idle(3000);
    check("t6_queue", exp_q.size(), 0);

    // random traffic
    do_reset();
    eng_lat_min = 1; eng_lat_max = 40;
    spurious_en = 1;
    for (int i = 0; i < 4000; i++)
      drive_cycle($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 249) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    spurious_en = 0;
    wait_idle(5000);
    touched = 0;
    for (int i = 0; i < 16; i++)
      if (m_touched[i]) begin
        touched++;
        check("final_screen", m_screen[i], {1'b0, m_table[i]});
      end
    check("final_touched_any", touched > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
